// File: rtl/fractal_pkg.sv
// +----------------------------------------------------------------------+
// | fractal_pkg: shared types and helpers for the escape-time engine.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package fractal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    OUT  = 2'd2
  } fe_state_e;

  typedef enum logic {
    MODE_JULIA  = 1'b0,
    MODE_MANDEL = 1'b1
  } fe_mode_e;

  // |z|^2 bound of 4.0 expressed in the engine's Q format
  function automatic logic [63:0] escape_threshold(input int frac);
    return 64'd4 << frac;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fx_mult_sat.sv
// +----------------------------------------------------------------------+
// | fx_mult_sat: combinational signed Q multiply, shift and saturate.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fx_mult_sat #(
  parameter int DATA_WIDTH      = 32,
  parameter int FRACTIONAL_BITS = 24
) (
  input  logic signed [DATA_WIDTH-1:0] i_a,
  input  logic signed [DATA_WIDTH-1:0] i_b,
  output logic signed [DATA_WIDTH-1:0] o_p
);

  localparam logic signed [DATA_WIDTH-1:0] c_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [2*DATA_WIDTH-1:0] w_shift;
  logic                           w_fits;

  assign w_prod  = i_a * i_b;
  assign w_shift = w_prod >>> FRACTIONAL_BITS;
  // Result fits only if every bit above the kept sign bit copies it
  assign w_fits  = (&w_shift[2*DATA_WIDTH-1:DATA_WIDTH-1]) |
                   (~|w_shift[2*DATA_WIDTH-1:DATA_WIDTH-1]);
  assign o_p     = w_fits ? w_shift[DATA_WIDTH-1:0]
                          : (w_shift[2*DATA_WIDTH-1] ? c_MIN : c_MAX);

endmodule

`default_nettype wire

// File: rtl/fractal_engine.sv
// +----------------------------------------------------------------------+
// | fractal_engine: Julia/Mandelbrot escape-time iterator, one step/clk. |
// | Optional FRACTAL_ENGINE_MAG_EN adds mag_o.  Revision: 1.0             |
// +----------------------------------------------------------------------+
`default_nettype none

module fractal_engine
  import fractal_pkg::*;
#(
  parameter int   INTEGER_BITS    = 8,
  parameter int   FRACTIONAL_BITS = 24,
  parameter int   MAX_ITER_WIDTH  = 16,
  parameter int   TAG_WIDTH       = 20,
  localparam int  DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic                         mode_i,
  input  logic signed [DATA_WIDTH-1:0] px_i,
  input  logic signed [DATA_WIDTH-1:0] py_i,
  input  logic signed [DATA_WIDTH-1:0] cx_i,
  input  logic signed [DATA_WIDTH-1:0] cy_i,
  input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
  input  logic [TAG_WIDTH-1:0]         tag_i,
  input  logic                         flush_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [MAX_ITER_WIDTH-1:0]    iter_o,
  output logic                         escaped_o,
  output logic [TAG_WIDTH-1:0]         tag_o
`ifdef FRACTAL_ENGINE_MAG_EN
  ,
  output logic [DATA_WIDTH:0]          mag_o
`endif
);

  localparam logic [DATA_WIDTH:0] c_ESC_THRESH =
    (DATA_WIDTH+1)'(escape_threshold(FRACTIONAL_BITS));

  fe_state_e                    r_state;
  logic signed [DATA_WIDTH-1:0] r_x, r_y, r_cx, r_cy;
  logic [MAX_ITER_WIDTH-1:0]    r_iter, r_max_iter, r_iter_q;
  logic [TAG_WIDTH-1:0]         r_tag, r_tag_q;
  logic                         r_esc_q, r_in_ready, r_out_valid;
`ifdef FRACTAL_ENGINE_MAG_EN
  logic [DATA_WIDTH:0]          r_mag_q;
`endif

  logic signed [DATA_WIDTH-1:0] w_x2, w_y2, w_xy, w_x_next, w_y_next;
  logic [DATA_WIDTH:0]          w_mag;
  logic                         w_escape, w_limit;

  fx_mult_sat #(.DATA_WIDTH(DATA_WIDTH), .FRACTIONAL_BITS(FRACTIONAL_BITS))
    u_mul_xx (.i_a(r_x), .i_b(r_x), .o_p(w_x2));
  fx_mult_sat #(.DATA_WIDTH(DATA_WIDTH), .FRACTIONAL_BITS(FRACTIONAL_BITS))
    u_mul_yy (.i_a(r_y), .i_b(r_y), .o_p(w_y2));
  fx_mult_sat #(.DATA_WIDTH(DATA_WIDTH), .FRACTIONAL_BITS(FRACTIONAL_BITS))
    u_mul_xy (.i_a(r_x), .i_b(r_y), .o_p(w_xy));

  // Squares are never negative, so the extra bit keeps the sum from wrapping
  assign w_mag    = {1'b0, w_x2} + {1'b0, w_y2};
  assign w_escape = (w_mag >= c_ESC_THRESH);
  assign w_limit  = (r_iter == r_max_iter);
  assign w_x_next = w_x2 - w_y2 + r_cx;
  assign w_y_next = w_xy + w_xy + r_cy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_iter      <= '0;
      r_max_iter  <= '0;
      r_tag       <= '0;
      r_iter_q    <= '0;
      r_esc_q     <= 1'b0;
      r_tag_q     <= '0;
`ifdef FRACTAL_ENGINE_MAG_EN
      r_mag_q     <= '0;
`endif
    end else if (flush_i) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i && r_in_ready) begin
            r_max_iter <= max_iter_i;
            r_tag      <= tag_i;
            r_iter     <= '0;
            if (fe_mode_e'(mode_i) == MODE_MANDEL) begin
              r_x  <= '0;
              r_y  <= '0;
              r_cx <= px_i;
              r_cy <= py_i;
            end else begin
              r_x  <= px_i;
              r_y  <= py_i;
              r_cx <= cx_i;
              r_cy <= cy_i;
            end
            r_state    <= ITER;
            r_in_ready <= 1'b0;
          end
        end
        ITER: begin
          // Escape is tested before the limit so a coincidence reports escaped
          if (w_escape || w_limit) begin
            r_iter_q    <= r_iter;
            r_esc_q     <= w_escape;
            r_tag_q     <= r_tag;
`ifdef FRACTAL_ENGINE_MAG_EN
            r_mag_q     <= w_mag;
`endif
            r_state     <= OUT;
            r_out_valid <= 1'b1;
          end else begin
            r_x    <= w_x_next;
            r_y    <= w_y_next;
            r_iter <= r_iter + 1'b1;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign iter_o      = r_iter_q;
  assign escaped_o   = r_esc_q;
  assign tag_o       = r_tag_q;
`ifdef FRACTAL_ENGINE_MAG_EN
  assign mag_o       = r_mag_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fractal_engine.sv
// +----------------------------------------------------------------------+
// | tb_fractal_engine: randomized self-checking bench for fractal_engine.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fractal_engine;

  localparam int DW = 32;
  localparam int FB = 24;
  localparam int MW = 16;
  localparam int TW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mode = 1'b0;
  logic [DW-1:0] px = '0, py = '0, cx = '0, cy = '0;
  logic [MW-1:0] max_iter = '0;
  logic [TW-1:0] tag = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [MW-1:0] iter;
  logic          escaped;
  logic [TW-1:0] tag_out;
`ifdef FRACTAL_ENGINE_MAG_EN
  logic [DW:0]   mag;
`endif

  int errors = 0;
  int checks = 0;

  fractal_engine dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mode_i(mode), .px_i(px), .py_i(py), .cx_i(cx), .cy_i(cy),
    .max_iter_i(max_iter), .tag_i(tag), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .iter_o(iter), .escaped_o(escaped), .tag_o(tag_out)
`ifdef FRACTAL_ENGINE_MAG_EN
    , .mag_o(mag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Real-number style reference: Q8.24 values held as plain 64-bit integers
  function automatic longint smul(input longint a, input longint b);
    longint p;
    p = (a * b) >>> FB;
    if (p > 64'sh7FFFFFFF) p = 64'sh7FFFFFFF;
    if (p < -64'sh80000000) p = -64'sh80000000;
    return p;
  endfunction

  function automatic longint wrap32(input longint v);
    int t;
    t = int'(v);
    return longint'(t);
  endfunction

  task automatic ref_model(input bit mandel, input longint zx, input longint zy,
                           input longint kx, input longint ky, input int lim,
                           output int n, output bit esc, output longint m);
    longint x, y, ccx, ccy, x2, y2, xy;
    bit done;
    x = mandel ? 0 : zx;   y = mandel ? 0 : zy;
    ccx = mandel ? zx : kx; ccy = mandel ? zy : ky;
    n = 0; esc = 0; m = 0; done = 0;
    while (!done) begin
      x2 = smul(x, x);
      y2 = smul(y, y);
      m  = x2 + y2;
      if (m >= (longint'(4) << FB)) begin
        esc = 1; done = 1;
      end else if (n == lim) begin
        esc = 0; done = 1;
      end else begin
        xy = smul(x, y);
        x  = wrap32(x2 - y2 + ccx);
        y  = wrap32(2 * xy + ccy);
        n++;
      end
    end
  endtask

  task automatic run_job(input bit m, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                         input int lim, input logic [TW-1:0] t, input int bp);
    int n, k;
    bit esc, found;
    longint mg;
    ref_model(m, longint'($signed(a)), longint'($signed(b)),
              longint'($signed(c0)), longint'($signed(c1)), lim, n, esc, mg);
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    mode = m; px = a; py = b; cx = c0; cy = c1; max_iter = MW'(lim); tag = t;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0; found = 0;
    while (!found && k < lim + 20) begin
      @(negedge clk);
      k++;
      if (out_valid) found = 1;
    end
    check("latency", k, n + 2);
    check("ready_busy", in_ready, 0);
    check("iter", iter, n);
    check("escaped", escaped, esc);
    check("tag", tag_out, t);
`ifdef FRACTAL_ENGINE_MAG_EN
    check("mag", mag, mg);
`endif
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_data", {iter, escaped, tag_out}, {MW'(n), esc, t});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("ready_after", in_ready, 1);
    check("valid_after", out_valid, 0);
  endtask

  function automatic logic [DW-1:0] rnd_coord();
    int r;
    if ($urandom_range(0, 7) == 0) return $urandom;
    r = int'($urandom_range(0, 32'h04800000)) - 32'h02400000;
    return r;
  endfunction

  initial begin
    int viol;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_outs", {iter, escaped, tag_out}, '0);
    rst_n = 1'b1;

    run_job(1, 32'h0, 32'h0, 32'h0, 32'h0, 100, 20'h00011, 0);
    run_job(1, 32'h02000000, 32'h0, 32'h0, 32'h0, 50, 20'h00022, 0);
    run_job(0, 32'h03000000, 32'h0, 32'h0, 32'h0, 0, 20'h00033, 0);
    run_job(0, 32'h0, 32'h0, 32'hFF400000, 32'h0, 30, 20'h00044, 10);
    run_job(0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0, 32'h0, 20, 20'h00055, 0);

    for (int j = 0; j < 24; j++)
      run_job(1'($urandom_range(0, 1)), rnd_coord(), rnd_coord(), rnd_coord(),
              rnd_coord(), int'($urandom_range(0, 40)), TW'($urandom),
              int'($urandom_range(0, 3)));

    // Abort mid-job, then offer a job alongside a flush
    @(negedge clk);
    mode = 1'b1; px = '0; py = '0; max_iter = 16'd100; tag = 20'hABCDE;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    check("flush_noaccept", in_ready, 1);
    viol = 0;
    repeat (110) begin
      @(negedge clk);
      if (out_valid || !in_ready) viol++;
    end
    check("flush_quiet", viol, 0);

    // Asynchronous reset while a job is iterating
    @(negedge clk);
    mode = 1'b0; px = 32'h00100000; py = '0; cx = '0; cy = '0; tag = 20'h12345;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_outs", {iter, escaped, tag_out}, '0);
`ifdef FRACTAL_ENGINE_MAG_EN
    check("midrst_mag", mag, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_job(1, 32'hFF000000, 32'h00400000, 32'h0, 32'h0, 25, 20'h00077, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
